// File: rtl/matrix_burst_loader_pkg.sv
// Shared definitions for the burst matrix loader: register map, STATUS bit
// positions and the FSM state encoding.
package matrix_burst_loader_pkg;

    localparam logic [1:0] REG_PTR        = 2'd0;
    localparam logic [1:0] REG_DIM_STATUS = 2'd1;
    localparam logic [1:0] REG_STRIDE     = 2'd2;
    localparam logic [1:0] REG_COUNT      = 2'd3;

    localparam int BUSY = 0;
    localparam int IRQ  = 1;
    localparam int ERR  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RECV   = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/matrix_burst_addr_gen.sv
// Walks the N x N element grid for the loader: row/col position, beats left in
// the open burst, the byte address of the next burst and its length.
module matrix_burst_addr_gen
    import matrix_burst_loader_pkg::*;
#(
    parameter int MAX_DIM   = 32,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 30,
    parameter int BURST_LEN = 4,
    localparam int IDX_W    = $clog2(MAX_DIM),
    localparam int DIM_W    = IDX_W + 1,
    localparam int BC_W     = $clog2(BURST_LEN) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [DIM_W-1:0]  dim_i,
    input  logic [ADDR_W-1:0] ptr_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic              accept_i,
    input  logic              beat_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BC_W-1:0]   blen_o,
    output logic [IDX_W-1:0]  row_o,
    output logic [IDX_W-1:0]  col_o,
    output logic              last_beat_o,
    output logic              last_elem_o
);

    localparam int BYTES = DATA_W / 8;

    logic [DIM_W-1:0]  dim_q, dim_d;
    logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [BC_W-1:0]   beats_q, beats_d;
    logic [DIM_W-1:0]  dim_m1, rem;
    logic              col_wrap;

    assign dim_m1   = dim_q - DIM_W'(1);
    assign col_wrap = ({1'b0, col_q} == dim_m1);
    assign rem      = dim_q - {1'b0, col_q};

    // Bursts are clipped at the row end so row_base only ever moves between bursts.
    assign blen_o      = (int'(rem) >= BURST_LEN) ? BC_W'(BURST_LEN) : BC_W'(rem);
    assign addr_o      = base_q + ADDR_W'(col_q) * ADDR_W'(BYTES);
    assign row_o       = row_q;
    assign col_o       = col_q;
    assign last_beat_o = (beats_q == BC_W'(1));
    assign last_elem_o = col_wrap && ({1'b0, row_q} == dim_m1);

    always_comb begin
        dim_d   = dim_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        beats_d = beats_q;
        if (start_i) begin
            dim_d   = dim_i;
            row_d   = '0;
            col_d   = '0;
            base_d  = ptr_i;
            beats_d = '0;
        end else if (accept_i) begin
            beats_d = blen_o;
        end else if (beat_i) begin
            beats_d = beats_q - BC_W'(1);
            if (col_wrap) begin
                col_d  = '0;
                row_d  = row_q + IDX_W'(1);
                base_d = base_q + stride_i;
            end else begin
                col_d  = col_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dim_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            base_q  <= '0;
            beats_q <= '0;
        end else begin
            dim_q   <= dim_d;
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: rtl/matrix_burst_loader.sv
// Fetches an N x N matrix over an Avalon-MM burst master into the matrix RAM,
// programmed through a 4-register Avalon-MM slave; raises a level irq when done.
module matrix_burst_loader
    import matrix_burst_loader_pkg::*;
#(
    parameter int MAX_DIM   = 32,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 30,
    parameter int BURST_LEN = 4,
    localparam int IDX_W    = $clog2(MAX_DIM),
    localparam int DIM_W    = IDX_W + 1,
    localparam int RAM_AW   = 2 * IDX_W,
    localparam int BC_W     = $clog2(BURST_LEN) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] address,
    output logic [BC_W-1:0]   burstcount,
    output logic              read,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    input  logic              readdatavalid,
    input  logic [1:0]        slave_address,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    input  logic              slave_read,
    output logic [31:0]       slave_readdata,
    output logic              slave_waitrequest,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              irq
);

    localparam int CNT_W = 2 * IDX_W + 1;

    state_e            state_q, state_d;
    logic [31:0]       ptr_q, ptr_d, stride_q, stride_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              busy_q, busy_d, irq_q, irq_d, err_q, err_d;
    logic              ram_we_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_data_q;

    logic              start, accept, beat, dim_ok;
    logic [DIM_W-1:0]  wr_dim;
    logic [ADDR_W-1:0] gen_addr;
    logic [BC_W-1:0]   gen_blen;
    logic [IDX_W-1:0]  row, col;
    logic              last_beat, last_elem;

    assign wr_dim = slave_writedata[DIM_W-1:0];
    assign dim_ok = (wr_dim != '0) && (wr_dim <= DIM_W'(MAX_DIM));
    assign accept = (state_q == ISSUE) && !waitrequest;
    assign beat   = (state_q == RECV) && readdatavalid;

    matrix_burst_addr_gen #(
        .MAX_DIM  (MAX_DIM),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BURST_LEN(BURST_LEN)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start),
        .dim_i      (wr_dim),
        .ptr_i      (ADDR_W'(ptr_q)),
        .stride_i   (ADDR_W'(stride_q)),
        .accept_i   (accept),
        .beat_i     (beat),
        .addr_o     (gen_addr),
        .blen_o     (gen_blen),
        .row_o      (row),
        .col_o      (col),
        .last_beat_o(last_beat),
        .last_elem_o(last_elem)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        stride_d = stride_q;
        count_d  = count_q;
        busy_d   = busy_q;
        irq_d    = irq_q;
        err_d    = err_q;
        start    = 1'b0;

        // Clear first so that a same-cycle set below takes priority.
        if (slave_read && (slave_address == REG_DIM_STATUS))
            irq_d = 1'b0;

        if (slave_write && !busy_q) begin
            case (slave_address)
                REG_PTR:    ptr_d    = slave_writedata;
                REG_STRIDE: stride_d = slave_writedata;
                REG_DIM_STATUS: begin
                    if (dim_ok) begin
                        start   = 1'b1;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        count_d = '0;
                        state_d = ISSUE;
                    end else begin
                        err_d = 1'b1;
                        irq_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: ;
            ISSUE: begin
                if (!waitrequest)
                    state_d = RECV;
            end
            RECV: begin
                if (readdatavalid) begin
                    count_d = count_q + CNT_W'(1);
                    if (last_beat)
                        state_d = last_elem ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                irq_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            stride_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            irq_q    <= irq_d;
            err_q    <= err_d;
        end
    end

    // RAM write stage: one register between the read beat and the RAM port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            ram_we_q <= beat;
            if (beat) begin
                ram_addr_q <= {row, col};
                ram_data_q <= readdata;
            end
        end
    end

    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            REG_PTR:        slave_readdata = ptr_q;
            REG_DIM_STATUS: begin
                slave_readdata[BUSY] = busy_q;
                slave_readdata[IRQ]  = irq_q;
                slave_readdata[ERR]  = err_q;
            end
            REG_STRIDE:     slave_readdata = stride_q;
            REG_COUNT:      slave_readdata = 32'(count_q);
            default: ;
        endcase
    end

    assign read              = (state_q == ISSUE);
    assign address           = read ? gen_addr : '0;
    assign burstcount        = read ? gen_blen : '0;
    assign slave_waitrequest = 1'b0;
    assign ram_we            = ram_we_q;
    assign ram_addr          = ram_addr_q;
    assign ram_data          = ram_data_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_matrix_burst_loader.sv
// Scoreboard bench for matrix_burst_loader: expected bursts and RAM writes are
// queued from the programmed PTR/STRIDE/N and retired as the DUT produces them.
module tb_matrix_burst_loader;

    localparam int MAX_DIM   = 32;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 30;
    localparam int BURST_LEN = 4;
    localparam int BC_W      = 3;
    localparam int RAM_AW    = 10;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] address;
    logic [BC_W-1:0]   burstcount;
    logic              read;
    logic              waitrequest = 1'b0;
    logic [DATA_W-1:0] readdata = '0;
    logic              readdatavalid = 1'b0;
    logic [1:0]        slave_address = '0;
    logic              slave_write = 1'b0;
    logic [31:0]       slave_writedata = '0;
    logic              slave_read = 1'b0;
    logic [31:0]       slave_readdata;
    logic              slave_waitrequest;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_we;
    logic              irq;

    matrix_burst_loader dut (
        .clk(clk), .reset_n(reset_n),
        .address(address), .burstcount(burstcount), .read(read),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .slave_address(slave_address), .slave_write(slave_write),
        .slave_writedata(slave_writedata), .slave_read(slave_read),
        .slave_readdata(slave_readdata), .slave_waitrequest(slave_waitrequest),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] a; logic [BC_W-1:0] bc; } burst_t;
    typedef struct { logic [RAM_AW-1:0] a; logic [DATA_W-1:0] d; } ramw_t;

    burst_t            exp_burst[$];
    ramw_t             exp_ram[$];
    logic [DATA_W-1:0] beat_q[$];
    int                n_vec = 0;
    int                n_err = 0;
    int                n_acc = 0;
    int                stall_req = 0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[13:0], 2'b01, ~a[15:0]};
    endfunction

    task automatic plan(input logic [31:0] ptr, input logic [31:0] stride, input int n);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c += BURST_LEN) begin
                burst_t b;
                b.a  = ADDR_W'(ptr + 32'(r) * stride + 32'(c) * 4);
                b.bc = BC_W'((n - c < BURST_LEN) ? (n - c) : BURST_LEN);
                exp_burst.push_back(b);
            end
            for (int c = 0; c < n; c++) begin
                ramw_t w;
                w.a = RAM_AW'(r * MAX_DIM + c);
                w.d = mem_word(ADDR_W'(ptr + 32'(r) * stride + 32'(c) * 4));
                exp_ram.push_back(w);
            end
        end
    endtask

    // Avalon fabric model: optional stall on a request, then zero-wait burst data.
    initial begin : fabric
        logic [ADDR_W-1:0] h_addr;
        logic [BC_W-1:0]   h_bc;
        bit                stalling;
        burst_t            e;
        stalling = 1'b0;
        forever begin
            @(negedge clk);
            if (beat_q.size() > 0) begin
                readdatavalid = 1'b1;
                readdata      = beat_q.pop_front();
            end else begin
                readdatavalid = 1'b0;
                readdata      = '0;
            end
            if (read === 1'b1) begin
                if (stalling) begin
                    n_vec++;
                    if ({address, burstcount} !== {h_addr, h_bc}) begin
                        n_err++;
                        $display("FAIL stall_hold: addr=%h bc=%0d want addr=%h bc=%0d",
                                 address, burstcount, h_addr, h_bc);
                    end
                end
                if (stall_req > 0) begin
                    if (!stalling) begin
                        h_addr = address;
                        h_bc   = burstcount;
                    end
                    stalling    = 1'b1;
                    stall_req--;
                    waitrequest = 1'b1;
                end else begin
                    stalling    = 1'b0;
                    waitrequest = 1'b0;
                    n_acc++;
                    n_vec++;
                    if (exp_burst.size() == 0) begin
                        n_err++;
                        $display("FAIL burst_unexpected: addr=%h bc=%0d want no request",
                                 address, burstcount);
                    end else begin
                        e = exp_burst.pop_front();
                        if ({address, burstcount} !== {e.a, e.bc}) begin
                            n_err++;
                            $display("FAIL burst_req: addr=%h bc=%0d want addr=%h bc=%0d",
                                     address, burstcount, e.a, e.bc);
                        end
                    end
                    for (int i = 0; i < int'(burstcount); i++)
                        beat_q.push_back(mem_word(address + ADDR_W'(i * 4)));
                end
            end else begin
                waitrequest = 1'b0;
            end
        end
    end

    initial begin : ram_monitor
        ramw_t w;
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                n_vec++;
                if (exp_ram.size() == 0) begin
                    n_err++;
                    $display("FAIL ram_unexpected: addr=%0d data=%h want no write", ram_addr, ram_data);
                end else begin
                    w = exp_ram.pop_front();
                    if ({ram_addr, ram_data} !== {w.a, w.d}) begin
                        n_err++;
                        $display("FAIL ram_write: addr=%0d data=%h want addr=%0d data=%h",
                                 ram_addr, ram_data, w.a, w.d);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        slave_address = a;
        slave_read    = 1'b1;
        #1 d = slave_readdata;
        @(negedge clk);
        slave_read    = 1'b0;
    endtask

    task automatic wait_irq(output bit ok);
        int i;
        i = 0;
        while (irq !== 1'b1 && i < 4000) begin
            @(negedge clk);
            i++;
        end
        ok = (irq === 1'b1);
    endtask

    task automatic run_cmd(input logic [31:0] ptr, input logic [31:0] stride, input int n,
                           input string tag, output logic [31:0] cnt, output logic [31:0] st);
        bit ok;
        plan(ptr, stride, n);
        wr(0, ptr);
        wr(2, stride);
        wr(1, 32'(n));
        wait_irq(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_irq: irq=%b want 1", tag, irq);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_burst.size() != 0 || exp_ram.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: bursts_left=%0d writes_left=%0d want 0 0",
                     tag, exp_burst.size(), exp_ram.size());
        end
        rd(3, cnt);
        rd(1, st);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #1;
        n_vec++;
        if ({read, address, burstcount, ram_we, ram_addr, ram_data, irq, slave_waitrequest} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: read=%b addr=%h bc=%0d we=%b ra=%0d rd=%h irq=%b want all 0",
                     read, address, burstcount, ram_we, ram_addr, ram_data, irq);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            rd(2'(r), v);
            n_vec++;
            if (v !== 32'h0) begin
                n_err++;
                $display("FAIL reset_reg%0d: got %h want 0", r, v);
            end
        end
    endtask

    task automatic test_dim4();
        logic [31:0] cnt, st;
        int acc0;
        acc0 = n_acc;
        run_cmd(32'h1000, 32'd16, 4, "dim4", cnt, st);
        n_vec++;
        if (cnt !== 32'd16) begin n_err++; $display("FAIL dim4_count: got %0d want 16", cnt); end
        n_vec++;
        if (st !== 32'b010) begin n_err++; $display("FAIL dim4_status: got %b want 010", st); end
        n_vec++;
        if (n_acc - acc0 != 4) begin n_err++; $display("FAIL dim4_bursts: got %0d want 4", n_acc - acc0); end
        rd(1, st);
        n_vec++;
        if (st !== 32'b000) begin n_err++; $display("FAIL dim4_irq_clear: got %b want 000", st); end
    endtask

    task automatic test_dim6_split();
        logic [31:0] cnt, st;
        int acc0;
        acc0 = n_acc;
        run_cmd(32'h2000, 32'd24, 6, "dim6", cnt, st);
        n_vec++;
        if (cnt !== 32'd36) begin n_err++; $display("FAIL dim6_count: got %0d want 36", cnt); end
        n_vec++;
        if (n_acc - acc0 != 12) begin n_err++; $display("FAIL dim6_bursts: got %0d want 12", n_acc - acc0); end
        n_vec++;
        if (st !== 32'b010) begin n_err++; $display("FAIL dim6_status: got %b want 010", st); end
    endtask

    task automatic test_waitrequest();
        logic [31:0] cnt, st;
        int acc0;
        acc0 = n_acc;
        stall_req = 5;
        run_cmd(32'h3000, 32'd8, 2, "stall", cnt, st);
        n_vec++;
        if (n_acc - acc0 != 2) begin n_err++; $display("FAIL stall_accepts: got %0d want 2", n_acc - acc0); end
        n_vec++;
        if (cnt !== 32'd4) begin n_err++; $display("FAIL stall_count: got %0d want 4", cnt); end
    endtask

    task automatic test_bad_dim();
        logic [31:0] st;
        logic [31:0] dims[2];
        int acc0;
        dims[0] = 32'd0;
        dims[1] = 32'd33;
        acc0 = n_acc;
        for (int k = 0; k < 2; k++) begin
            wr(1, dims[k]);
            rd(1, st);
            n_vec++;
            if (st !== 32'b110) begin n_err++; $display("FAIL baddim%0d_status: got %b want 110", dims[k], st); end
            rd(1, st);
            n_vec++;
            if (st !== 32'b100) begin n_err++; $display("FAIL baddim%0d_cleared: got %b want 100", dims[k], st); end
        end
        n_vec++;
        if (n_acc != acc0 || read !== 1'b0) begin
            n_err++;
            $display("FAIL baddim_traffic: requests=%0d read=%b want 0 0", n_acc - acc0, read);
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] cnt, st, p;
        bit ok;
        plan(32'h4000, 32'd32, 4);
        wr(0, 32'h4000);
        wr(2, 32'd32);
        wr(1, 32'd4);
        wr(1, 32'd2);
        wr(0, 32'h9000);
        wait_irq(ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL busy_irq: irq=%b want 1", irq); end
        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_burst.size() != 0 || exp_ram.size() != 0) begin
            n_err++;
            $display("FAIL busy_drain: bursts_left=%0d writes_left=%0d want 0 0", exp_burst.size(), exp_ram.size());
        end
        rd(0, p);
        n_vec++;
        if (p !== 32'h4000) begin n_err++; $display("FAIL busy_ptr: got %h want 4000", p); end
        rd(3, cnt);
        n_vec++;
        if (cnt !== 32'd16) begin n_err++; $display("FAIL busy_count: got %0d want 16", cnt); end
        rd(1, st);
        n_vec++;
        if (st !== 32'b010) begin n_err++; $display("FAIL busy_status: got %b want 010", st); end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] cnt, st;
        int i, acc0;
        plan(32'h5000, 32'd16, 4);
        wr(0, 32'h5000);
        wr(2, 32'd16);
        wr(1, 32'd4);
        i = 0;
        while (exp_ram.size() > 14 && i < 200) begin
            @(negedge clk);
            i++;
        end
        n_vec++;
        if (exp_ram.size() > 14) begin n_err++; $display("FAIL rstmid_progress: writes_left=%0d want <=14", exp_ram.size()); end
        exp_ram.delete();
        exp_burst.delete();
        acc0 = n_acc;
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({read, address, burstcount, ram_we, ram_addr, ram_data, irq} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: read=%b addr=%h bc=%0d we=%b ra=%0d rd=%h irq=%b want all 0",
                     read, address, burstcount, ram_we, ram_addr, ram_data, irq);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        i = 0;
        while (beat_q.size() > 0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_acc != acc0) begin n_err++; $display("FAIL rstmid_requests: got %0d want 0", n_acc - acc0); end
        rd(1, st);
        n_vec++;
        if (st !== 32'b000) begin n_err++; $display("FAIL rstmid_status: got %b want 000", st); end
        run_cmd(32'h6000, 32'd8, 2, "rstmid_fresh", cnt, st);
        n_vec++;
        if (cnt !== 32'd4) begin n_err++; $display("FAIL rstmid_fresh_count: got %0d want 4", cnt); end
        n_vec++;
        if (st !== 32'b010) begin n_err++; $display("FAIL rstmid_fresh_status: got %b want 010", st); end
    endtask

    initial begin
        test_reset();
        test_dim4();
        test_dim6_split();
        test_waitrequest();
        test_bad_dim();
        test_busy_writes();
        test_reset_mid_burst();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_burst_loader.md
Name: matrix_burst_loader

Overview:
Parametrised successor to the single-beat matrix fetch engine. The CPU programs a base pointer, a row stride and a dimension N over an Avalon-MM slave. The block fetches the N×N matrix of DATA_W-bit words over an Avalon-MM burst-read master and writes each element into a matrix RAM write port at row*MAX_DIM+col. Completion (or a rejected command) raises a level irq that the CPU clears. The block sits between the Nios II system bus and the determinant datapath RAM.

Parameters:
MAX_DIM, 32, largest supported N; power of two; RAM_AW = 2*log2(MAX_DIM).
DATA_W, 32, element/bus word width; byte step per column = DATA_W/8.
ADDR_W, 30, master byte-address width.
BURST_LEN, 4, maximum burst beats; power of two, 1..16; BC_W = log2(BURST_LEN)+1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  out  ADDR_W  master byte address
burstcount  out  BC_W  master burst length
read  out  1  master read request
waitrequest  in  1  master stall
readdata  in  DATA_W  master read data
readdatavalid  in  1  master data beat valid
slave_address  in  2  register select
slave_write  in  1  register write strobe
slave_writedata  in  32  register write data
slave_read  in  1  register read strobe
slave_readdata  out  32  register read data (combinational on slave_address)
slave_waitrequest  out  1  tied 0
ram_addr  out  RAM_AW  matrix RAM write address
ram_data  out  DATA_W  matrix RAM write data
ram_we  out  1  matrix RAM write enable
irq  out  1  interrupt, level

Behaviour:
- Reset (async, reset_n=0): read=0, address=0, burstcount=0, ram_we=0, ram_addr=0, ram_data=0, irq=0. All registers are 0 and the FSM is IDLE. Deasserting reset mid-transfer abandons the transfer; late readdatavalid beats are ignored while in IDLE.
- Registers:
  - 0: PTR, R/W.
  - 1: write = DIM/start; read = STATUS {29'b0, error, irq, busy}.
  - 2: STRIDE, bytes between rows, R/W.
  - 3: COUNT, elements written this command, RO.
- A write to reg 1 while busy is ignored, as are writes to PTR and STRIDE while busy.
- Start with 1 ≤ N ≤ MAX_DIM, where N = slave_writedata[log2(MAX_DIM):0]: latch N, set busy, clear error and COUNT, go to ISSUE.
- Start with N=0 or N>MAX_DIM: no bus traffic; error=1 and irq=1 the next cycle; busy stays 0.
- Any slave_read of address 1 clears irq the cycle after. If the clear coincides with completion, the set wins.
- FSM states: IDLE → ISSUE → RECV → (ISSUE | FINISH) → IDLE.
- ISSUE:
  - read=1, address = PTR + row*STRIDE + col*(DATA_W/8), truncated to ADDR_W.
  - burstcount = min(BURST_LEN, N-col). A burst never crosses a row.
  - Outputs hold until a cycle with waitrequest=0, then read drops and the FSM enters RECV.
- RECV:
  - Each readdatavalid beat: ram_we=1, ram_addr=row*MAX_DIM+col, ram_data=readdata, registered one cycle later. COUNT and col increment.
  - When col reaches N-1: col wraps to 0 and row increments.
  - After the last beat of a burst: go to FINISH if row*N+col has reached N*N, else ISSUE.
  - Only one burst is outstanding at a time.
- FINISH, 1 cycle: busy=0, irq=1, back to IDLE.
- Command-to-first-request latency: 1 cycle after the DIM write.
- Request accepted → data depends on the fabric.
- RAM write: 1 cycle after each readdatavalid.

Decomposition:
- Shared package holds:
  - register offsets (REG_PTR=0, REG_DIM_STATUS=1, REG_STRIDE=2, REG_COUNT=3);
  - STATUS bit indices (BUSY=0, IRQ=1, ERR=2);
  - FSM state encoding (IDLE, ISSUE, RECV, FINISH).
- One sub-module, matrix_burst_addr_gen, is natural. It tracks row/col, beats left in the burst, the next byte address (row base += STRIDE on wrap) and the burst length.
- The top level holds the register file, the FSM and the RAM write stage.

Test Plan:
1. PTR=0x1000, STRIDE=16, DIM=4, BURST_LEN=4, zero-wait memory → four bursts:
   - addresses 0x1000/0x1010/0x1020/0x1030, burstcount 4;
   - ram_addr {0..3, 32..35, 64..67, 96..99} with matching data;
   - irq=1, COUNT=16, STATUS=0b010.
2. DIM=6, STRIDE=24, BURST_LEN=4 → per row, bursts of 4 then 2 (address offsets +0 and +16). Total 12 bursts, COUNT=36.
3. waitrequest held 5 cycles on the first request → address/burstcount/read stable throughout; exactly one request is accepted.
4. DIM=0, then DIM=33 → no read asserted; STATUS=0b110 next cycle. Reading STATUS clears irq, giving 0b100.
5. DIM write while busy, and a PTR write mid-transfer → both ignored; the transfer completes against the original PTR.
6. reset_n pulsed low mid-burst, with readdatavalid beats continuing → all outputs 0 immediately, no ram_we afterwards. A fresh DIM=2 then completes normally.
